zap_ram_port_arbiter: RTL and testbench

//  Shares one zap_ram_simple instance (3-cycle read latency, separate read and write ports, i_clken freeze) between NUM_REQ requesters.

---
 rtl/zap_ram_arb_pkg.sv | 16 +
 rtl/zap_ram_port_arbiter_if.sv | 34 +++
 rtl/zap_rr_arbiter.sv | 50 +++++
 rtl/zap_ram_port_arbiter.sv | 107 ++++++++++
 tb/tb_zap_ram_port_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zap_ram_arb_pkg.sv
// Shared definitions for the zap RAM port arbiter.
//   RD_LATENCY  : cycles from read grant to response when the RAM is not frozen.
//   NUM_REQ_MAX : largest requester count the tag id field can name.
//   rd_tag_t    : one in-flight read slot {valid, requester id}.
package zap_ram_arb_pkg;

    localparam int RD_LATENCY  = 3;
    localparam int NUM_REQ_MAX = 16;
    localparam int IW          = $clog2(NUM_REQ_MAX);

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/zap_ram_port_arbiter_if.sv
// Client-side bus of the zap RAM port arbiter.
//   i_rd_valid/i_rd_addr -> o_rd_ready                  : read request channel
//   i_wr_valid/i_wr_addr/i_wr_data -> o_wr_ready        : write request channel
//   o_rsp_valid/o_rsp_data <- i_rsp_ready               : read response channel
// Names keep the arbiter's point of view; requester k uses slice k of each
// packed field. modport master = requesters, modport slave = arbiter.
interface zap_ram_port_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int NUM_REQ = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_REQ-1:0]       i_rd_valid;
    logic [NUM_REQ*AW-1:0]    i_rd_addr;
    logic [NUM_REQ-1:0]       o_rd_ready;
    logic [NUM_REQ-1:0]       i_wr_valid;
    logic [NUM_REQ*AW-1:0]    i_wr_addr;
    logic [NUM_REQ*WIDTH-1:0] i_wr_data;
    logic [NUM_REQ-1:0]       o_wr_ready;
    logic [NUM_REQ-1:0]       o_rsp_valid;
    logic [WIDTH-1:0]         o_rsp_data;
    logic [NUM_REQ-1:0]       i_rsp_ready;

    modport master (
        output i_rd_valid, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_rsp_ready,
        input  o_rd_ready, o_wr_ready, o_rsp_valid, o_rsp_data
    );

    modport slave (
        input  i_rd_valid, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_rsp_ready,
        output o_rd_ready, o_wr_ready, o_rsp_valid, o_rsp_data
    );
endinterface

// File: rtl/zap_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req        : request vector
//   en         : grant enable; with en=0 no grant is issued and ptr holds
//   gnt        : one-hot grant (or zero)
//   gnt_idx    : index of the granted requester (valid when |gnt)
// The search starts at ptr and wraps N-1 -> 0; after a grant the pointer
// moves to the slot just past the winner.
module zap_rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic          found;

    // NOTE: every signal written here gets a default first, so no path through
    // the loop leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end
endmodule

// File: rtl/zap_ram_port_arbiter.sv
// Shares one 3-cycle-latency RAM (separate read/write ports, clken freeze)
// between NUM_REQ requesters.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   bus              : client read/write/response channels (slave side)
//   o_busy           : any read in flight
//   o_ram_*          : RAM clken, write port and read address
//   i_ram_rd_data    : RAM registered read data
// Independent round-robin arbiters serve the read and write ports. A tag
// pipeline that shadows the RAM read latency routes each result back to
// its requester. When the response at the end of the pipe is not accepted
// the whole arbiter and the RAM freeze together, so data and tags stay aligned.
module zap_ram_port_arbiter
    import zap_ram_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    zap_ram_port_arbiter_if.slave      bus,
    output logic                       o_busy,
    output logic                       o_ram_clken,
    output logic                       o_ram_wr_en,
    output logic [$clog2(DEPTH)-1:0]   o_ram_wr_addr,
    output logic [WIDTH-1:0]           o_ram_wr_data,
    output logic [$clog2(DEPTH)-1:0]   o_ram_rd_addr,
    input  logic [WIDTH-1:0]           i_ram_rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               stall;
    logic               grant_en;
    logic [NUM_REQ-1:0] rd_gnt;
    logic [NUM_REQ-1:0] wr_gnt;
    logic [PW-1:0]      rd_idx;
    logic [PW-1:0]      wr_idx;
    logic [AW-1:0]      rd_addr_q;
    logic [NUM_REQ-1:0] rsp_valid;
    rd_tag_t            tag [RD_LATENCY];

    // Response decode from the last tag stage.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
        assign rsp_valid[k] = tag[RD_LATENCY-1].v && (tag[RD_LATENCY-1].id == IW'(k));
    end

    // A presented but unaccepted response freezes the RAM and the arbiter.
    assign stall    = |(rsp_valid & ~bus.i_rsp_ready);
    assign grant_en = i_reset_n & ~stall;

    zap_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .req     (bus.i_rd_valid),
        .en      (grant_en),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx)
    );

    zap_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .req     (bus.i_wr_valid),
        .en      (grant_en),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx)
    );

    assign bus.o_rd_ready  = rd_gnt;
    assign bus.o_wr_ready  = wr_gnt;
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_rsp_data  = i_ram_rd_data;

    assign o_ram_clken   = ~stall;
    assign o_ram_wr_en   = |wr_gnt;
    assign o_ram_wr_addr = bus.i_wr_addr[int'(wr_idx)*AW +: AW];
    assign o_ram_wr_data = bus.i_wr_data[int'(wr_idx)*WIDTH +: WIDTH];

    // Read address is presented combinationally for the granting edge and
    // otherwise parked on the last granted address.
    assign o_ram_rd_addr = (|rd_gnt) ? bus.i_rd_addr[int'(rd_idx)*AW +: AW] : rd_addr_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_addr_q <= '0;
        end else if (|rd_gnt) begin
            rd_addr_q <= bus.i_rd_addr[int'(rd_idx)*AW +: AW];
        end
    end

    // NOTE: the tag stages must be reset because their valid bits decide
    // what is in flight; the RAM array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) tag[i] <= '0;
        end else if (!stall) begin
            tag[0] <= '{v: |rd_gnt, id: IW'(rd_idx)};
            for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) o_busy = o_busy | tag[i].v;
    end
endmodule

// File: tb/tb_zap_ram_port_arbiter.sv
// Self-checking bench for zap_ram_port_arbiter: a behavioural RAM plant,
// a table of grant/response vectors, directed multi-cycle sequences and a
// randomized phase, all watched by a transaction-level reference model.
module tb_zap_ram_port_arbiter;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 32;
    localparam int NUM_REQ = 2;
    localparam int AW      = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    zap_ram_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) bus ();

    logic             busy, ram_clken, ram_wr_en;
    logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
    logic [WIDTH-1:0] ram_wr_data, ram_rd_data;

    zap_ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .bus           (bus),
        .o_busy        (busy),
        .o_ram_clken   (ram_clken),
        .o_ram_wr_en   (ram_wr_en),
        .o_ram_wr_addr (ram_wr_addr),
        .o_ram_wr_data (ram_wr_data),
        .o_ram_rd_addr (ram_rd_addr),
        .i_ram_rd_data (ram_rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] init_val(input int a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    // RAM plant: 3-stage read address pipe, output read from the array after
    // the third edge, so writes up to two active cycles later are seen.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra  [3];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (ram_clken && ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        if (ram_clken) begin
            ra[0] <= ram_rd_addr;
            ra[1] <= ra[0];
            ra[2] <= ra[1];
        end
    end
    assign ram_rd_data = mem[ra[2]];

    // ---------------- reference model (transaction level) ----------------
    typedef struct { int id; int addr; int g; } rd_txn_t;
    typedef struct { int w; int addr; logic [WIDTH-1:0] data; } wr_txn_t;
    rd_txn_t rq [$];
    wr_txn_t wlog [$];
    int m_rptr, m_wptr, m_act, m_erd, m_ewr;
    logic m_vis, m_stall;

    // First requester at or after ptr in cyclic order.
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int k);
        return (k < 0) ? '0 : NUM_REQ'(1 << k);
    endfunction

    // Read granted in active cycle g sees every write granted up to g+2.
    function automatic logic [WIDTH-1:0] ref_data(input int addr, input int g);
        for (int i = wlog.size() - 1; i >= 0; i--)
            if (wlog[i].addr == addr && wlog[i].w <= g + 2) return wlog[i].data;
        return init_val(addr);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("mon_rst_rd_gnt", bus.o_rd_ready, '0);
            check("mon_rst_wr_gnt", bus.o_wr_ready, '0);
            rq.delete();
            wlog.delete();
            m_rptr = 0;
            m_wptr = 0;
        end else begin
            m_vis   = (rq.size() > 0) && (m_act - rq[0].g >= 3);
            m_stall = m_vis && (((bus.i_rsp_ready >> rq[0].id) & 2'b01) == 2'b00);
            check("mon_rsp_valid", bus.o_rsp_valid, m_vis ? onehot(rq[0].id) : '0);
            check("mon_busy", busy, rq.size() != 0);
            check("mon_clken", ram_clken, !m_stall);
            if (m_vis)
                check($sformatf("mon_rsp_data_a%0d", rq[0].addr), bus.o_rsp_data,
                      ref_data(rq[0].addr, rq[0].g));
            m_erd = m_stall ? -1 : pick(bus.i_rd_valid, m_rptr);
            m_ewr = m_stall ? -1 : pick(bus.i_wr_valid, m_wptr);
            check("mon_rd_gnt", bus.o_rd_ready, onehot(m_erd));
            check("mon_wr_gnt", bus.o_wr_ready, onehot(m_ewr));
            check("mon_wr_en", ram_wr_en, m_ewr >= 0);
            if (m_erd >= 0)
                check("mon_rd_addr", ram_rd_addr, bus.i_rd_addr[m_erd*AW +: AW]);
            if (m_ewr >= 0) begin
                check("mon_wr_addr", ram_wr_addr, bus.i_wr_addr[m_ewr*AW +: AW]);
                check("mon_wr_data", ram_wr_data, bus.i_wr_data[m_ewr*WIDTH +: WIDTH]);
            end
            if (!m_stall) begin
                if (m_vis) void'(rq.pop_front());
                if (m_erd >= 0) begin
                    rq.push_back('{id: m_erd, addr: int'(bus.i_rd_addr[m_erd*AW +: AW]), g: m_act});
                    m_rptr = (m_erd + 1) % NUM_REQ;
                end
                if (m_ewr >= 0) begin
                    wlog.push_back('{w: m_act, addr: int'(bus.i_wr_addr[m_ewr*AW +: AW]),
                                     data: bus.i_wr_data[m_ewr*WIDTH +: WIDTH]});
                    m_wptr = (m_ewr + 1) % NUM_REQ;
                end
                m_act++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_rd(input int k, input logic v, input int a);
        bus.i_rd_valid[k] = v;
        bus.i_rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int k, input logic v, input int a, input logic [WIDTH-1:0] d);
        bus.i_wr_valid[k] = v;
        bus.i_wr_addr[k*AW +: AW] = AW'(a);
        bus.i_wr_data[k*WIDTH +: WIDTH] = d;
    endtask

    task automatic idle();
        bus.i_rd_valid  = '0;
        bus.i_wr_valid  = '0;
        bus.i_rsp_ready = '1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [1:0] rd_v;
        logic [1:0] wr_v;
        logic [1:0] exp_rd;
        logic [1:0] exp_wr;
        logic [1:0] exp_rsp;
    } vec_t;
    vec_t tbl [8];

    int n0, n1, j;

    initial begin
        tbl[0] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[1] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        tbl[2] = '{2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
        tbl[3] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01};
        tbl[4] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        tbl[5] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
        tbl[6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        tbl[7] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10};

        bus.i_rd_addr = '0;
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        idle();
        rst_n = 1'b0;

        // Reset state, with requests pending that must not be granted.
        bus.i_rd_valid = 2'b11;
        bus.i_wr_valid = 2'b11;
        next_cycle();
        next_cycle();
        sample();
        check("reset_rd_gnt", bus.o_rd_ready, 2'b00);
        check("reset_wr_gnt", bus.o_wr_ready, 2'b00);
        check("reset_rsp_valid", bus.o_rsp_valid, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_clken", ram_clken, 1'b1);
        idle();
        next_cycle();
        rst_n = 1'b1;

        // 1. single read, 3-cycle latency
        set_rd(0, 1'b1, 5);
        sample();
        check("t1_gnt", bus.o_rd_ready, 2'b01);
        next_cycle();
        idle();
        sample();
        check("t1_busy", busy, 1'b1);
        check("t1_no_early_rsp", bus.o_rsp_valid, 2'b00);
        next_cycle();
        next_cycle();
        sample();
        check("t1_rsp_valid", bus.o_rsp_valid, 2'b01);
        check("t1_rsp_data", bus.o_rsp_data, 32'hA5A5_0005);
        next_cycle();

        // Table: grant patterns and response routing from a fresh reset.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_rd(0, tbl[c].rd_v[0], 6);
            set_rd(1, tbl[c].rd_v[1], 13);
            set_wr(0, tbl[c].wr_v[0], 20, 32'h1000 + 32'(c));
            set_wr(1, tbl[c].wr_v[1], 21, 32'h2000 + 32'(c));
            sample();
            check($sformatf("tbl%0d_rd", c), bus.o_rd_ready, tbl[c].exp_rd);
            check($sformatf("tbl%0d_wr", c), bus.o_wr_ready, tbl[c].exp_wr);
            check($sformatf("tbl%0d_rsp", c), bus.o_rsp_valid, tbl[c].exp_rsp);
            next_cycle();
        end

        // 2. RR fairness with both requesters streaming
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 11; c++) begin
            set_rd(0, n0 < 4, 1 + n0);
            set_rd(1, n1 < 4, 9 + n1);
            sample();
            if (c < 8) check($sformatf("t2_gnt_c%0d", c), bus.o_rd_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c >= 3) begin
                j = c - 3;
                check($sformatf("t2_rsp_c%0d", c), bus.o_rsp_valid, (j % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("t2_data_c%0d", c), bus.o_rsp_data,
                      init_val((j % 2 == 0) ? 1 + j / 2 : 9 + j / 2));
            end
            if (bus.o_rd_ready[0]) n0++;
            if (bus.o_rd_ready[1]) n1++;
            next_cycle();
        end
        idle();

        // 3. backpressure on r1 for four cycles
        do_reset();
        set_rd(1, 1'b1, 10);
        next_cycle();
        idle();
        set_rd(0, 1'b1, 2);
        next_cycle();
        idle();
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            bus.i_rsp_ready = 2'b01;
            bus.i_rd_valid  = 2'b11;
            set_wr(0, 1'b1, 30, 32'hCAFE_0000);
            sample();
            check($sformatf("t3_stall%0d_rsp", c), bus.o_rsp_valid, 2'b10);
            check($sformatf("t3_stall%0d_data", c), bus.o_rsp_data, 32'hA5A5_000A);
            check($sformatf("t3_stall%0d_clken", c), ram_clken, 1'b0);
            check($sformatf("t3_stall%0d_rd", c), bus.o_rd_ready, 2'b00);
            check($sformatf("t3_stall%0d_wr", c), bus.o_wr_ready, 2'b00);
            next_cycle();
        end
        idle();
        sample();
        check("t3_release_rsp", bus.o_rsp_valid, 2'b10);
        check("t3_release_clken", ram_clken, 1'b1);
        next_cycle();
        sample();
        check("t3_next_rsp", bus.o_rsp_valid, 2'b01);
        check("t3_next_data", bus.o_rsp_data, 32'hA5A5_0002);
        next_cycle();

        // 4. same-cycle read-after-write from different requesters
        do_reset();
        set_wr(0, 1'b1, 7, 32'hDEAD_BEEF);
        set_rd(1, 1'b1, 7);
        sample();
        check("t4_wr_gnt", bus.o_wr_ready, 2'b01);
        check("t4_rd_gnt", bus.o_rd_ready, 2'b10);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();
        sample();
        check("t4_rsp", bus.o_rsp_valid, 2'b10);
        check("t4_data", bus.o_rsp_data, 32'hDEAD_BEEF);
        next_cycle();

        // 5. write contention on one address
        do_reset();
        set_wr(0, 1'b1, 3, 32'h11);
        set_wr(1, 1'b1, 3, 32'h22);
        sample();
        check("t5_first_gnt", bus.o_wr_ready, 2'b01);
        check("t5_first_data", ram_wr_data, 32'h11);
        next_cycle();
        bus.i_wr_valid[0] = 1'b0;
        sample();
        check("t5_second_gnt", bus.o_wr_ready, 2'b10);
        check("t5_second_data", ram_wr_data, 32'h22);
        next_cycle();
        idle();
        set_rd(0, 1'b1, 3);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();
        sample();
        check("t5_rsp", bus.o_rsp_valid, 2'b01);
        check("t5_data", bus.o_rsp_data, 32'h22);
        next_cycle();

        // 6. reset with two reads in flight
        do_reset();
        set_rd(0, 1'b1, 1);
        next_cycle();
        idle();
        set_rd(1, 1'b1, 2);
        next_cycle();
        idle();
        rst_n = 1'b0;
        bus.i_rd_valid = 2'b11;
        sample();
        check("t6_rst_gnt", bus.o_rd_ready, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        set_rd(0, 1'b1, 4);
        set_rd(1, 1'b1, 8);
        sample();
        check("t6_post_gnt", bus.o_rd_ready, 2'b01);
        check("t6_post_busy", busy, 1'b0);
        check("t6_post_rsp", bus.o_rsp_valid, 2'b00);
        next_cycle();
        idle();
        for (int c = 0; c < 2; c++) begin
            sample();
            check($sformatf("t6_dropped%0d", c), bus.o_rsp_valid, 2'b00);
            next_cycle();
        end
        sample();
        check("t6_new_rsp", bus.o_rsp_valid, 2'b01);
        check("t6_new_data", bus.o_rsp_data, 32'hA5A5_0004);
        next_cycle();

        // Randomized traffic, judged by the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                set_rd(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
                set_wr(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
                bus.i_rsp_ready[k] = ($urandom_range(0, 3) != 0);
            end
            next_cycle();
        end
        idle();
        for (int c = 0; c < 8; c++) next_cycle();
        sample();
        check("drain_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
